demux_1to16_reg: RTL and testbench
==================================

DEMUX_1TO16_REG -- requirements
Module: demux_1to16_reg

Interface
REQ-001 Parameter width, default 4, is the data width of the input word and of each output channel.
REQ-002 Parameter swidth, default 4, is the select width; only swidth=4 (16 channels) is supported.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i  input  width  data word to route.
REQ-006 sel  input  swidth  destination channel index 0..15.
REQ-007 valid_in  input  1  write qualifier; i and sel are sampled only when it is high.
REQ-008 clear  input  1  synchronous clear of the frame-tracking state.
REQ-009 o0..o15  output  width each  registered channel hold registers.
REQ-010 dest_strobe  output  16  one-hot, one-cycle pulse marking the channel written on the previous edge.
REQ-011 written  output  16  sticky per-channel written flags for the current frame.
REQ-012 frame_done  output  1  one-cycle pulse when all 16 channels have been written.

Function
REQ-013 On a rising edge with valid_in=1 and clear=0, o[sel] SHALL load i; all other channels SHALL hold.
REQ-014 Write latency SHALL be one cycle: the new value is visible on o[sel] in the cycle after the sampling edge.
REQ-015 dest_strobe[sel] SHALL be 1 for exactly the cycle after a write; dest_strobe SHALL be all zero after any edge without a write.
REQ-016 A write SHALL set written[sel]; a repeated write to a channel SHALL overwrite the data and leave written[sel] at 1.
REQ-017 When written OR onehot(sel) equals 16'hFFFF at a write edge, written SHALL become 16'h0000 and frame_done SHALL be 1 for the following cycle only.
REQ-018 A write SHALL also assert dest_strobe in the same cycle as frame_done.
REQ-019 clear=1 at an edge SHALL zero written and dest_strobe, deassert frame_done, and reset the auto pointer; o0..o15 SHALL hold.
REQ-020 clear and valid_in both high at the same edge: clear SHALL win, and the write SHALL be dropped entirely (no data, strobe, or flag).
REQ-021 valid_in=0: sel and i are don't-care; no state SHALL change except that dest_strobe and frame_done return to 0.

Reset
REQ-022 reset=1 SHALL immediately, without a clock edge, force o0..o15=0, dest_strobe=0, written=0, frame_done=0, and auto pointer=0.
REQ-023 reset asserted mid-frame SHALL discard partial frame progress; the first write after release SHALL begin a new frame.
REQ-024 Deassertion of reset SHALL take effect at the next rising edge of clk.

Configuration
REQ-025 Macro DEMUX_AUTOSEL_EN: when defined, the block SHALL add input auto_mode (1 bit) and an internal 4-bit pointer.
REQ-026 With DEMUX_AUTOSEL_EN and auto_mode=1, the pointer SHALL replace sel as the destination and SHALL increment modulo 16 on each accepted write (15 wraps to 0).
REQ-027 With DEMUX_AUTOSEL_EN and auto_mode=0, sel SHALL be used and the pointer SHALL hold.
REQ-028 Without DEMUX_AUTOSEL_EN, the auto_mode port and the pointer SHALL be absent and sel SHALL always be used.

Verification
REQ-029 Reset, then write i=4'hA with sel=5 -> next cycle o5=4'hA, dest_strobe=16'h0020, written=16'h0020; other outputs 0.
REQ-030 Write channels 0..15 with i=channel index -> frame_done=1 for one cycle after the write to channel 15, written=0, and o15=4'hF.
REQ-031 Write channel 3 twice (4'h1, then 4'h7), then the other 15 channels -> o3=4'h7; frame_done fires only after the 16th distinct channel.
REQ-032 Drive clear=1 with valid_in=1, sel=2, i=4'h9 after writes to channels 0 and 1 -> written=0, o2 unchanged, dest_strobe=0.
REQ-033 Assert reset asynchronously between clock edges after 8 writes -> all outputs 0 immediately; a further 16 writes are required for frame_done.
REQ-034 With DEMUX_AUTOSEL_EN defined and auto_mode=1, make 17 writes with data 0..16 (4-bit truncated) -> o0..o15 = 0..15 after 16 writes; the 17th write loads 4'h0 into o0 and drives dest_strobe=16'h0001 (pointer wrap).

Source files
------------

// File: rtl/demux_1to16_reg_if.sv
// demux_1to16_reg_if: bus bundle for demux_1to16_reg; auto_mode exists only when DEMUX_AUTOSEL_EN is defined
interface demux_1to16_reg_if #(parameter int width = 4, parameter int swidth = 4);
  logic [width-1:0] i;
  logic [swidth-1:0] sel;
  logic valid_in;
  logic clear;
`ifdef DEMUX_AUTOSEL_EN
  logic auto_mode;
`endif
  logic [width-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [width-1:0] o8, o9, o10, o11, o12, o13, o14, o15;
  logic [15:0] dest_strobe;
  logic [15:0] written;
  logic frame_done;
`ifdef DEMUX_AUTOSEL_EN
  modport master (output i, sel, valid_in, clear, auto_mode,
                  input o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11, o12, o13, o14, o15,
                  dest_strobe, written, frame_done);
  modport slave (input i, sel, valid_in, clear, auto_mode,
                 output o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11, o12, o13, o14, o15,
                 dest_strobe, written, frame_done);
`else
  modport master (output i, sel, valid_in, clear,
                  input o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11, o12, o13, o14, o15,
                  dest_strobe, written, frame_done);
  modport slave (input i, sel, valid_in, clear,
                 output o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11, o12, o13, o14, o15,
                 dest_strobe, written, frame_done);
`endif
endinterface

// File: rtl/demux_1to16_reg.sv
// demux_1to16_reg: registered 1-to-16 demux with frame tracking; DEMUX_AUTOSEL_EN adds an auto-increment destination pointer
module demux_1to16_reg #(
  parameter int width = 4,
  parameter int swidth = 4
) (
  input logic clk,
  input logic reset,
  demux_1to16_reg_if.slave bus
);
  logic [15:0][width-1:0] regs;
  logic [15:0] strobe, written, onehot, merged;
  logic fd, wr;
  logic [swidth-1:0] dst;
`ifdef DEMUX_AUTOSEL_EN
  logic [swidth-1:0] ptr;
  assign dst = bus.auto_mode ? ptr : bus.sel;
  // pointer restarts on clear and advances only on accepted auto-mode writes
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (bus.clear) ptr <= '0;
    else if (wr && bus.auto_mode) ptr <= ptr + 1'b1;
`else
  assign dst = bus.sel;
`endif
  assign wr = bus.valid_in & ~bus.clear;
  assign onehot = 16'd1 << dst;
  assign merged = written | onehot;
  // channel data, strobe and frame tracking; clear beats a simultaneous write
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      regs <= '0;
      strobe <= '0;
      written <= '0;
      fd <= 1'b0;
    end else begin
      strobe <= wr ? onehot : '0;
      fd <= wr && &merged;
      if (bus.clear) written <= '0;
      else if (wr) begin
        regs[dst] <= bus.i;
        written <= &merged ? '0 : merged;
      end
    end
  assign bus.dest_strobe = strobe;
  assign bus.written = written;
  assign bus.frame_done = fd;
  assign bus.o0 = regs[0];
  assign bus.o1 = regs[1];
  assign bus.o2 = regs[2];
  assign bus.o3 = regs[3];
  assign bus.o4 = regs[4];
  assign bus.o5 = regs[5];
  assign bus.o6 = regs[6];
  assign bus.o7 = regs[7];
  assign bus.o8 = regs[8];
  assign bus.o9 = regs[9];
  assign bus.o10 = regs[10];
  assign bus.o11 = regs[11];
  assign bus.o12 = regs[12];
  assign bus.o13 = regs[13];
  assign bus.o14 = regs[14];
  assign bus.o15 = regs[15];
endmodule

// File: tb/tb_demux_1to16_reg.sv
// tb_demux_1to16_reg: table-driven and sequence checks for demux_1to16_reg
module tb_demux_1to16_reg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] o_all;
  demux_1to16_reg_if bus();
  demux_1to16_reg dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign o_all = {bus.o15, bus.o14, bus.o13, bus.o12, bus.o11, bus.o10, bus.o9, bus.o8,
                  bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1, bus.o0};
  typedef struct {
    logic v;
    logic c;
    logic [3:0] sel;
    logic [3:0] i;
    logic [3:0] ch;
    logic [3:0] exp_o;
    logic [15:0] exp_s;
    logic [15:0] exp_w;
    logic exp_fd;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic c, input logic [3:0] s, input logic [3:0] d);
    bus.valid_in = v;
    bus.clear = c;
    bus.sel = s;
    bus.i = d;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.clear = 1'b0;
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'd5, 4'hA, 4'd5, 4'hA, 16'h0020, 16'h0020, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 4'd5, 4'hF, 4'd5, 4'hA, 16'h0000, 16'h0020, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 4'd0, 4'h3, 4'd0, 4'h3, 16'h0001, 16'h0021, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 4'd1, 4'h4, 4'd1, 4'h4, 16'h0002, 16'h0023, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'd2, 4'h9, 4'd2, 4'h0, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'd2, 4'h6, 4'd2, 4'h6, 16'h0004, 16'h0004, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 4'd2, 4'h8, 4'd2, 4'h8, 16'h0004, 16'h0004, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 4'd7, 4'hF, 4'd7, 4'h0, 16'h0000, 16'h0004, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 4'd5, 4'h0, 4'd5, 4'hA, 16'h0000, 16'h0000, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 4'd15, 4'hC, 4'd15, 4'hC, 16'h8000, 16'h8000, 1'b0};
    bus.valid_in = 1'b0;
    bus.clear = 1'b0;
    bus.sel = '0;
    bus.i = '0;
`ifdef DEMUX_AUTOSEL_EN
    bus.auto_mode = 1'b0;
`endif
    #1;
    chk("rst_o", o_all, 64'h0);
    chk("rst_strobe", {48'h0, bus.dest_strobe}, 64'h0);
    chk("rst_written", {48'h0, bus.written}, 64'h0);
    chk("rst_fd", {63'h0, bus.frame_done}, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].v, tbl[k].c, tbl[k].sel, tbl[k].i);
      chk($sformatf("tbl%0d_o", k), {60'h0, o_all[tbl[k].ch*4 +: 4]}, {60'h0, tbl[k].exp_o});
      chk($sformatf("tbl%0d_strobe", k), {48'h0, bus.dest_strobe}, {48'h0, tbl[k].exp_s});
      chk($sformatf("tbl%0d_written", k), {48'h0, bus.written}, {48'h0, tbl[k].exp_w});
      chk($sformatf("tbl%0d_fd", k), {63'h0, bus.frame_done}, {63'h0, tbl[k].exp_fd});
      if (k == 0) chk("first_write_all_o", o_all, 64'h0000_0000_00A0_0000);
    end
    step(1'b0, 1'b1, 4'd0, 4'd0);
    for (int ch = 0; ch < 16; ch++) begin
      step(1'b1, 1'b0, 4'(ch), 4'(ch));
      chk($sformatf("full_fd%0d", ch), {63'h0, bus.frame_done}, {63'h0, ch == 15});
      chk($sformatf("full_strobe%0d", ch), {48'h0, bus.dest_strobe}, {48'h0, 16'd1 << ch});
    end
    chk("full_written", {48'h0, bus.written}, 64'h0);
    chk("full_o15", {60'h0, bus.o15}, 64'hF);
    step(1'b0, 1'b0, 4'd0, 4'd0);
    chk("full_fd_drop", {63'h0, bus.frame_done}, 64'h0);
    chk("idle_strobe", {48'h0, bus.dest_strobe}, 64'h0);
    step(1'b1, 1'b0, 4'd3, 4'h1);
    step(1'b1, 1'b0, 4'd3, 4'h7);
    chk("rep_written", {48'h0, bus.written}, 64'h0008);
    chk("rep_fd", {63'h0, bus.frame_done}, 64'h0);
    for (int ch = 0; ch < 16; ch++) begin
      if (ch != 3) begin
        step(1'b1, 1'b0, 4'(ch), 4'(ch));
        chk($sformatf("rep_fd%0d", ch), {63'h0, bus.frame_done}, {63'h0, ch == 15});
      end
    end
    chk("rep_o3", {60'h0, bus.o3}, 64'h7);
    step(1'b0, 1'b1, 4'd0, 4'd0);
    for (int ch = 0; ch < 8; ch++) step(1'b1, 1'b0, 4'(ch), 4'(ch + 1));
    #3;
    reset = 1'b1;
    #1;
    chk("async_o", o_all, 64'h0);
    chk("async_strobe", {48'h0, bus.dest_strobe}, 64'h0);
    chk("async_written", {48'h0, bus.written}, 64'h0);
    chk("async_fd", {63'h0, bus.frame_done}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int ch = 8; ch < 16; ch++) begin
      step(1'b1, 1'b0, 4'(ch), 4'(ch));
      chk($sformatf("post_rst_fd%0d", ch), {63'h0, bus.frame_done}, 64'h0);
    end
    for (int ch = 0; ch < 8; ch++) begin
      step(1'b1, 1'b0, 4'(ch), 4'(ch));
      chk($sformatf("post_rst_fd%0d", ch), {63'h0, bus.frame_done}, {63'h0, ch == 7});
    end
    chk("post_rst_written", {48'h0, bus.written}, 64'h0);
`ifdef DEMUX_AUTOSEL_EN
    bus.auto_mode = 1'b1;
    step(1'b0, 1'b1, 4'd0, 4'd0);
    for (int k = 0; k < 17; k++) begin
      step(1'b1, 1'b0, 4'(15 - (k % 16)), 4'(k));
      if (k == 15) begin
        chk("auto_o_all", o_all, 64'hFEDC_BA98_7654_3210);
        chk("auto_fd", {63'h0, bus.frame_done}, 64'h1);
      end
    end
    chk("auto_wrap_o0", {60'h0, bus.o0}, 64'h0);
    chk("auto_wrap_o1", {60'h0, bus.o1}, 64'h1);
    chk("auto_wrap_strobe", {48'h0, bus.dest_strobe}, 64'h0001);
    bus.auto_mode = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
